mem_splice_unit: RTL and testbench

- Data-memory access stage directly downstream of the multicycle control unit and datapath.
- Takes one load/store request at a time: effective address, store data, size, signedness.
- Loads: reads the aligned 64-bit doubleword, extracts the addressed lane and sign/zero-extends it.
- Sub-doubleword stores: performs read-modify-write on the doubleword; returns one response per request.

---
 rtl/mem_splice_unit_if.sv | 32 +++
 rtl/mem_splice_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_splice_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_splice_unit_if.sv
// Request/response and data-memory bus of the load/store splice stage.
// slave  : the splice unit (consumes req_*, mem_rdata; drives req_ready, resp_*, mem_*)
// master : the upstream requester plus the data memory model
interface mem_splice_unit_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_misaligned;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_wr, mem_wdata
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_wr, mem_wdata
   );
endinterface

// File: rtl/mem_splice_unit.sv
// Data-memory access stage: one load/store at a time against a 64-bit
// doubleword memory. Loads extract and extend the addressed lane(s);
// sub-doubleword stores do a read-modify-write of the doubleword.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : mem_splice_unit_if.slave (request, response and memory signals)
// Optional build macro MEM_SPLICE_LINE_REUSE_EN adds a one-entry line buffer
// holding the last doubleword read or written, letting hits skip READ.
module mem_splice_unit #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned MEM_LAT = 1
) (
   input logic              clk,
   input logic              reset,
   mem_splice_unit_if.slave bus
);
   localparam int unsigned CNT_W = 3;
   localparam int unsigned OFF_W = 3;
   localparam logic [1:0]  SZ_D  = 2'b00;
   localparam logic [1:0]  SZ_W  = 2'b01;
   localparam logic [1:0]  SZ_H  = 2'b10;
   localparam logic [1:0]  SZ_B  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

   // Low-order ones covering the access size.
   function automatic logic [DATA_W-1:0] f_size_mask(input logic [1:0] sz);
      case (sz)
         SZ_W:    f_size_mask = DATA_W'(32'hFFFF_FFFF);
         SZ_H:    f_size_mask = DATA_W'(16'hFFFF);
         SZ_B:    f_size_mask = DATA_W'(8'hFF);
         default: f_size_mask = '1;
      endcase
   endfunction

   // Shift the addressed lanes down to bit 0 and sign/zero-extend.
   function automatic logic [DATA_W-1:0] f_extract(input logic [DATA_W-1:0] dw,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [1:0]        sz,
                                                    input logic              uns);
      logic [DATA_W-1:0] sh;
      sh = dw >> {off, 3'b000};
      case (sz)
         SZ_W:    f_extract = uns ? {{(DATA_W-32){1'b0}}, sh[31:0]} : {{(DATA_W-32){sh[31]}}, sh[31:0]};
         SZ_H:    f_extract = uns ? {{(DATA_W-16){1'b0}}, sh[15:0]} : {{(DATA_W-16){sh[15]}}, sh[15:0]};
         SZ_B:    f_extract = uns ? {{(DATA_W-8){1'b0}},  sh[7:0]}  : {{(DATA_W-8){sh[7]}},   sh[7:0]};
         default: f_extract = sh;
      endcase
   endfunction

   // Replace the addressed lanes of dw with the low bytes of wd.
   function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] dw,
                                                  input logic [DATA_W-1:0] wd,
                                                  input logic [OFF_W-1:0]  off,
                                                  input logic [1:0]        sz);
      logic [DATA_W-1:0] mask;
      mask    = f_size_mask(sz) << {off, 3'b000};
      f_merge = (dw & ~mask) | ((wd << {off, 3'b000}) & mask);
   endfunction

   function automatic logic f_misaligned(input logic [OFF_W-1:0] off, input logic [1:0] sz);
      case (sz)
         SZ_D:    f_misaligned = |off;
         SZ_W:    f_misaligned = |off[1:0];
         SZ_H:    f_misaligned = off[0];
         default: f_misaligned = 1'b0;
      endcase
   endfunction

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_write, r_unsigned;
   logic [1:0]        r_size;
   logic [OFF_W-1:0]  r_off;
   logic [DATA_W-1:0] r_wdata;
   logic              r_ready, w_ready_nxt;
   logic              r_resp_valid, w_resp_valid_nxt;
   logic              r_resp_mis, w_resp_mis_nxt;
   logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_nxt;
   logic              r_mem_wr, w_mem_wr_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;

   logic              w_accept;
   logic [OFF_W-1:0]  w_off;
   logic [ADDR_W-1:0] w_line_addr;
   logic              w_hit;
   logic [DATA_W-1:0] w_buf_data;

   assign w_accept    = bus.req_valid && r_ready;
   assign w_off       = bus.req_addr[OFF_W-1:0];
   assign w_line_addr = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef MEM_SPLICE_LINE_REUSE_EN
   logic              r_buf_vld;
   logic [ADDR_W-1:0] r_buf_addr;
   logic [DATA_W-1:0] r_buf_data;

   assign w_hit      = r_buf_vld && (r_buf_addr == w_line_addr);
   assign w_buf_data = r_buf_data;

   // Line buffer tracks every read capture and every write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_buf_vld  <= 1'b0;
         r_buf_addr <= '0;
         r_buf_data <= '0;
      end else if (r_state == S_READ && r_cnt == '0) begin
         r_buf_vld  <= 1'b1;
         r_buf_addr <= r_mem_addr;
         r_buf_data <= bus.mem_rdata;
      end else if (r_state == S_WRITE) begin
         r_buf_vld  <= 1'b1;
         r_buf_addr <= r_mem_addr;
         r_buf_data <= r_mem_wdata;
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_buf_data = '0;
`endif

   // Next state plus next values of every registered output.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_resp_valid_nxt = 1'b0;
      w_resp_mis_nxt   = 1'b0;
      w_resp_rdata_nxt = '0;
      w_mem_wr_nxt     = 1'b0;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_wdata_nxt  = r_mem_wdata;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (f_misaligned(w_off, bus.req_size)) begin
                  w_state_nxt      = S_RESP;
                  w_resp_valid_nxt = 1'b1;
                  w_resp_mis_nxt   = 1'b1;
               end else if (!bus.req_write && w_hit) begin
                  w_state_nxt      = S_RESP;
                  w_resp_valid_nxt = 1'b1;
                  w_resp_rdata_nxt = f_extract(w_buf_data, w_off, bus.req_size, bus.req_unsigned);
               end else if (bus.req_write && (bus.req_size == SZ_D || w_hit)) begin
                  w_state_nxt     = S_WRITE;
                  w_mem_wr_nxt    = 1'b1;
                  w_mem_addr_nxt  = w_line_addr;
                  w_mem_wdata_nxt = (bus.req_size == SZ_D) ? bus.req_wdata :
                                    f_merge(w_buf_data, bus.req_wdata, w_off, bus.req_size);
               end else begin
                  w_state_nxt    = S_READ;
                  w_cnt_nxt      = CNT_W'(MEM_LAT);
                  w_mem_addr_nxt = w_line_addr;
               end
            end
         end
         S_READ: begin
            // Read data is valid in the last READ cycle, when the counter hits zero.
            if (r_cnt == '0) begin
               if (r_write) begin
                  w_state_nxt     = S_WRITE;
                  w_mem_wr_nxt    = 1'b1;
                  w_mem_wdata_nxt = f_merge(bus.mem_rdata, r_wdata, r_off, r_size);
               end else begin
                  w_state_nxt      = S_RESP;
                  w_resp_valid_nxt = 1'b1;
                  w_resp_rdata_nxt = f_extract(bus.mem_rdata, r_off, r_size, r_unsigned);
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_WRITE: begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_ready_nxt = (w_state_nxt == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_write      <= 1'b0;
         r_unsigned   <= 1'b0;
         r_size       <= '0;
         r_off        <= '0;
         r_wdata      <= '0;
         r_ready      <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_mis   <= 1'b0;
         r_resp_rdata <= '0;
         r_mem_wr     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_ready      <= w_ready_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_mis   <= w_resp_mis_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_mem_wr     <= w_mem_wr_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_wdata  <= w_mem_wdata_nxt;
         if (w_accept) begin
            r_write    <= bus.req_write;
            r_unsigned <= bus.req_unsigned;
            r_size     <= bus.req_size;
            r_off      <= w_off;
            r_wdata    <= bus.req_wdata;
         end
      end
   end

   assign bus.req_ready       = r_ready;
   assign bus.resp_valid      = r_resp_valid;
   assign bus.resp_misaligned = r_resp_mis;
   assign bus.resp_rdata      = r_resp_rdata;
   assign bus.mem_wr          = r_mem_wr;
   assign bus.mem_addr        = r_mem_addr;
   assign bus.mem_wdata       = r_mem_wdata;
endmodule

// File: tb/tb_mem_splice_unit.sv
// Randomized bench for mem_splice_unit against a byte-level reference model.
module tb_mem_splice_unit;
   localparam int unsigned MEM_LAT = 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_splice_unit_if bus ();

   mem_splice_unit #(.MEM_LAT(MEM_LAT)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Data memory seen by the DUT; 32 doublewords covering byte addresses 0..255.
   logic [63:0] tb_mem  [32];
   logic [63:0] ref_mem [32];
   logic [63:0] pipe    [MEM_LAT];
   logic [63:0] last_addr;
   logic        pre_we = 1'b0;
   logic [4:0]  pre_idx;
   logic [63:0] pre_val;

   always @(posedge clk) begin
      if (pre_we) tb_mem[pre_idx] <= pre_val;
      else if (bus.mem_wr) tb_mem[bus.mem_addr[7:3]] <= bus.mem_wdata;
      pipe[0] <= bus.mem_addr;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign last_addr = pipe[MEM_LAT-1];
   always_comb bus.mem_rdata = tb_mem[last_addr[7:3]];

   // Reference line-buffer state (only consulted when the reuse build is enabled).
   bit          rb_vld = 1'b0;
   logic [63:0] rb_addr = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_load(input logic [63:0] dw, input int off, input int n, input bit uns);
      logic [63:0] v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = dw[8*(off+k) +: 8];
      if (!uns && n < 8 && v[8*n-1]) for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
      return v;
   endfunction

   task automatic preload(input int idx, input logic [63:0] val);
      pre_we = 1'b1; pre_idx = 5'(idx); pre_val = val;
      @(negedge clk);
      pre_we = 1'b0;
      ref_mem[idx] = val;
   endtask

   task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wd, output logic [63:0] rd);
      int n, off, lat, cyc, wcnt, wcyc, rcyc, tmo;
      bit mis, hit, got, rmis;
      logic [63:0] line, old, exp_rd, exp_wd, waddr, wdat, prev_maddr, resp_maddr;
      n    = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 2 : 1;
      off  = int'(addr[2:0]);
      mis  = (off % n) != 0;
      line = {addr[63:3], 3'b000};
      hit  = 1'b0;
`ifdef MEM_SPLICE_LINE_REUSE_EN
      hit  = rb_vld && rb_addr == line && !mis && !(wr && n == 8);
`endif
      if (mis)      lat = 1;
      else if (!wr) lat = hit ? 1 : MEM_LAT + 2;
      else if (n == 8) lat = 2;
      else          lat = hit ? 2 : MEM_LAT + 3;
      old    = ref_mem[addr[7:3]];
      exp_rd = (wr || mis) ? 64'd0 : ref_load(old, off, n, uns);
      exp_wd = old;
      for (int k = 0; k < n; k++) exp_wd[8*(off+k) +: 8] = wd[8*k +: 8];

      tmo = 0;
      while (!bus.req_ready && tmo < 20) begin @(negedge clk); tmo++; end
      if (!bus.req_ready) check("ready_wait", 64'(bus.req_ready), 64'd1);
      prev_maddr       = bus.mem_addr;
      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr  = {$urandom, $urandom};
      bus.req_wdata = {$urandom, $urandom};
      cyc = 1; got = 0; wcnt = 0; wcyc = 0; rcyc = 0; rmis = 0;
      rd = '0; waddr = '0; wdat = '0; resp_maddr = '0;
      while (!got && cyc <= 20) begin
         if (bus.mem_wr) begin
            wcnt++; wcyc = cyc; waddr = bus.mem_addr; wdat = bus.mem_wdata;
         end
         if (bus.resp_valid) begin
            got = 1; rcyc = cyc; rd = bus.resp_rdata; rmis = bus.resp_misaligned;
            resp_maddr = bus.mem_addr;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      check("resp_seen", 64'(got), 64'd1);
      check("latency", 64'(rcyc), 64'(lat));
      check("misaligned", 64'(rmis), 64'(mis));
      check("rdata", rd, exp_rd);
      check("wr_count", 64'(wcnt), (wr && !mis) ? 64'd1 : 64'd0);
      if (wr && !mis && wcnt > 0) begin
         check("wr_cycle", 64'(wcyc), 64'(lat - 1));
         check("wr_addr", waddr, line);
         check("wr_data", wdat, exp_wd);
      end
      if (!wr && hit) check("hit_maddr", resp_maddr, prev_maddr);
      @(negedge clk);
      check("resp_pulse", 64'(bus.resp_valid), 64'd0);
      check("ready_back", 64'(bus.req_ready), 64'd1);
      if (wr && !mis) ref_mem[addr[7:3]] = exp_wd;
      if (!mis && (wr || !hit)) begin rb_vld = 1'b1; rb_addr = line; end
   endtask

   task automatic reset_mid_op();
      int tmo = 0;
      while (!bus.req_ready && tmo < 20) begin @(negedge clk); tmo++; end
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
      bus.req_unsigned = 1'b0; bus.req_addr = 64'h4A; bus.req_wdata = 64'h1234;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("rst_cyc1_wr", 64'(bus.mem_wr), 64'd0);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_ready", 64'(bus.req_ready), 64'd0);
         check("rst_wr", 64'(bus.mem_wr), 64'd0);
         check("rst_resp", 64'(bus.resp_valid), 64'd0);
      end
      check("rst_maddr", bus.mem_addr, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_ready_rel", 64'(bus.req_ready), 64'd1);
      repeat (MEM_LAT + 3) begin
         @(negedge clk);
         check("rst_post_wr", 64'(bus.mem_wr), 64'd0);
         check("rst_post_resp", 64'(bus.resp_valid), 64'd0);
      end
      check("rst_mem", tb_mem[9], ref_mem[9]);
      rb_vld = 1'b0;
   endtask

   initial begin
      logic [63:0] rd;
      logic [63:0] a;
      logic [1:0]  sz;
      int          n;
      reset = 1'b0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = '0;
      bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_ready0", 64'(bus.req_ready), 64'd0);
      check("rst_resp0", 64'(bus.resp_valid), 64'd0);
      check("rst_mis0", 64'(bus.resp_misaligned), 64'd0);
      check("rst_rdata0", bus.resp_rdata, 64'd0);
      check("rst_wr0", 64'(bus.mem_wr), 64'd0);
      check("rst_maddr0", bus.mem_addr, 64'd0);
      check("rst_wdata0", bus.mem_wdata, 64'd0);
      for (int i = 0; i < 32; i++) preload(i, {$urandom, $urandom});
      reset = 1'b1;
      @(negedge clk);
      check("ready_out_of_rst", 64'(bus.req_ready), 64'd1);

      preload(2, 64'h1122_3344_5566_7788);
      do_req(1'b0, 2'b00, 1'b0, 64'h10, 64'd0, rd);
      check("plan_ld", rd, 64'h1122_3344_5566_7788);
`ifdef MEM_SPLICE_LINE_REUSE_EN
      do_req(1'b0, 2'b11, 1'b0, 64'h13, 64'd0, rd);
      check("plan_lb_hit", rd, 64'h55);
`endif
      preload(4, 64'h8000_0000_0000_0001);
      do_req(1'b0, 2'b01, 1'b0, 64'h24, 64'd0, rd);
      check("plan_lw_s", rd, 64'hFFFF_FFFF_8000_0000);
      do_req(1'b0, 2'b01, 1'b1, 64'h24, 64'd0, rd);
      check("plan_lw_u", rd, 64'h0000_0000_8000_0000);
      preload(6, 64'd0);
      do_req(1'b1, 2'b11, 1'b0, 64'h35, 64'hFFAB, rd);
      check("plan_sb_mem", ref_mem[6], 64'h0000_AB00_0000_0000);
      do_req(1'b0, 2'b10, 1'b0, 64'h41, 64'd0, rd);
      do_req(1'b1, 2'b11, 1'b0, 64'h10, 64'h5A, rd);
      do_req(1'b0, 2'b00, 1'b0, 64'h10, 64'd0, rd);
      check("plan_sb_ld", rd, 64'h1122_3344_5566_775A);
      reset_mid_op();

      for (int t = 0; t < 200; t++) begin
         sz = 2'($urandom_range(0, 3));
         n  = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 2 : 1;
         a  = 64'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) a = a & ~64'(n - 1);
         do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, rd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
